lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 16, width of the saturating error counter.
REQ-002 SHALL have parameter LOSS_THRESH, default 8, consecutive mismatches that declare loss of lock (range 1..255).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse; re-seeds checker and clears counters.
REQ-006 SHALL have port stop  in  1  one-cycle pulse; returns to IDLE, counters held.
REQ-007 SHALL have port in_valid  in  1  beat offered.
REQ-008 SHALL have port in_ready  out  1  beat accepted when in_valid && in_ready.
REQ-009 SHALL have port in_data  in  32  received data word.
REQ-010 SHALL have port in_addr  in  10  received address (used only with LFSR_CHK_ADDR_EN).
REQ-011 SHALL have port locked  out  1  high in CHECK state.
REQ-012 SHALL have port err  out  1  one-cycle pulse, registered, for each mismatching accepted beat.
REQ-013 SHALL have port err_count  out  ERR_CNT_W  total mismatches since start, saturating.
REQ-014 SHALL have port word_count  out  32  accepted beats since start, wrapping.

Function
REQ-015 SHALL generate expected data with step D'[0]=D[31], D'[1]=D[0]^D[31], D'[2]=D[1]^D[31], D'[22]=D[21]^D[31], other D'[i]=D[i-1]; seed 0xFFFFFFFF.
REQ-016 SHALL generate expected address with step A'[0]=A[9], A'[3]=A[2]^A[9], other A'[i]=A[i-1]; seed 0x3FF.
REQ-017 SHALL compare the first accepted beat after start against the seed, and each later beat against the step of the previous expected value.
REQ-018 SHALL implement states IDLE, CHECK, LOST; IDLE->CHECK on start; CHECK->LOST when consecutive-mismatch count reaches LOSS_THRESH; LOST->CHECK on next accepted beat; any state->IDLE on stop.
REQ-019 SHALL drive in_ready = (state != IDLE) && !start && !stop, combinationally.
REQ-020 SHALL in CHECK, on mismatch: pulse err next cycle, increment err_count (saturate at all-ones), increment consecutive count, still advance expected values.
REQ-021 SHALL in CHECK, on match: clear consecutive count, advance expected values.
REQ-022 SHALL in LOST, on accepted beat: load expected data with step(in_data) (and address with step(in_addr)), count it in word_count, not flag err, clear consecutive count.
REQ-023 SHALL increment word_count by one per accepted beat in CHECK or LOST, wrapping 0xFFFFFFFF->0.
REQ-024 SHALL, on start in any state, re-seed both LFSRs, clear err_count, word_count, consecutive count, enter CHECK; start and stop together: stop wins.
REQ-025 SHALL ignore in_valid in IDLE; no counter or LFSR change.

Reset
REQ-026 SHALL on rstn low immediately force: state IDLE, locked 0, err 0, err_count 0, word_count 0, consecutive count 0, data LFSR 0xFFFFFFFF, address LFSR 0x3FF.
REQ-027 SHALL, on reset mid-stream, discard the in-flight beat and require start to resume.

Configuration
REQ-028 SHALL with LFSR_CHK_ADDR_EN defined, treat a beat as mismatching if data or address differs from expected.
REQ-029 SHALL without LFSR_CHK_ADDR_EN, ignore in_addr, compare data only, and omit the address LFSR.

Structure
REQ-030 SHALL place seed constants, polynomial step functions and the state enum in package lfsr_pkg.
REQ-031 SHALL use one sub-module lfsr_step_gen (parameterized width/taps, load/advance) instantiated for data and, if enabled, address.

Verification
REQ-032 start, beats 0xFFFFFFFF, 0xFFBFFFF9 -> err never pulses, err_count 0, word_count 2, locked 1.
REQ-033 start, beats 0xFFFFFFFF, 0x00000000, 0xFFBFFFF9 -> exactly one err pulse after beat 2, err_count 1, locked stays 1 (third beat mismatches expected step: err_count 2).
REQ-034 LOSS_THRESH=8, eight zero beats after start -> locked drops after eighth; next beat X accepted without err; following beat step(X) matches, err_count 8.
REQ-035 LFSR_CHK_ADDR_EN, beats (0xFFFFFFFF,0x3FF),(0xFFBFFFF9,0x3F6) -> err on second only (expected addr 0x3F7).
REQ-036 rstn low mid-stream, then start and seed beat -> all outputs at reset values, then match with err_count 0; start with stop same cycle -> IDLE, in_ready 0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants, LFSR step function and FSM state type for lfsr_checker.
package lfsr_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned CONSEC_W = 8;

  localparam logic [DATA_W-1:0] DATA_SEED = 32'hFFFF_FFFF;
  localparam logic [DATA_W-1:0] DATA_TAPS = 32'h0040_0007;
  localparam logic [ADDR_W-1:0] ADDR_SEED = 10'h3FF;
  localparam logic [ADDR_W-1:0] ADDR_TAPS = 10'h009;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_LOST  = 2'd2
  } state_e;

  // Galois step for a w-bit register (w <= 32): shift left, fold MSB into taps.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v,
                                            input int unsigned w,
                                            input logic [31:0] taps);
    logic [31:0] mask;
    logic        msb;
    logic [31:0] res;
    mask = (32'h1 << w) - 32'h1;
    msb  = |(v & (32'h1 << (w - 32'd1)));
    res  = (v << 1) & mask;
    if (msb) begin
      res = res ^ (taps & mask);
    end
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] lfsr_step_data(input logic [DATA_W-1:0] d);
    return lfsr_step(d, DATA_W, DATA_TAPS);
  endfunction

  function automatic logic [ADDR_W-1:0] lfsr_step_addr(input logic [ADDR_W-1:0] a);
    return ADDR_W'(lfsr_step(32'(a), ADDR_W, 32'(ADDR_TAPS)));
  endfunction

endpackage

// File: rtl/lfsr_step_gen.sv
// Expected-value LFSR: re-seed, load an arbitrary value, or advance one step.
module lfsr_step_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned    W    = 32,
  parameter logic [W-1:0]   TAPS = '0,
  parameter logic [W-1:0]   SEED = '1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         seed_i,
  input  logic         load_i,
  input  logic         advance_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Next value: seed has priority over load, load over advance.
  always_comb begin
    value_d = value_q;
    if (seed_i) begin
      value_d = SEED;
    end else if (load_i) begin
      value_d = load_val_i;
    end else if (advance_i) begin
      value_d = W'(lfsr_step(32'(value_q), W, 32'(TAPS)));
    end
  end

  // LFSR register, resets to the seed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/lfsr_checker.sv
// PRBS stream checker with lock tracking and error/word counters.
// Optional address checking is enabled by defining LFSR_CHK_ADDR_EN.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned ERR_CNT_W   = 16,
  parameter int unsigned LOSS_THRESH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [ADDR_W-1:0]    in_addr,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WORD_W-1:0]    word_count
);

  localparam int unsigned CW1 = CONSEC_W + 1;

  state_e                state_q, state_d;
  logic                  locked_q, locked_d;
  logic                  err_q, err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [WORD_W-1:0]     word_cnt_q, word_cnt_d;
  logic [CONSEC_W-1:0]   consec_q, consec_d;
  logic [CW1-1:0]        consec_inc;

  logic                  seed_c, load_c, adv_c;
  logic                  accept;
  logic                  mismatch;
  logic [DATA_W-1:0]     data_exp;

  assign in_ready   = (state_q != ST_IDLE) && !start && !stop;
  assign accept     = in_valid && in_ready;
  assign consec_inc = CW1'(consec_q) + CW1'(1);

  lfsr_step_gen #(
    .W    (DATA_W),
    .TAPS (DATA_TAPS),
    .SEED (DATA_SEED)
  ) u_data_gen (
    .clk        (clk),
    .rstn       (rstn),
    .seed_i     (seed_c),
    .load_i     (load_c),
    .advance_i  (adv_c),
    .load_val_i (lfsr_step_data(in_data)),
    .value_o    (data_exp)
  );

`ifdef LFSR_CHK_ADDR_EN
  logic [ADDR_W-1:0] addr_exp;

  lfsr_step_gen #(
    .W    (ADDR_W),
    .TAPS (ADDR_TAPS),
    .SEED (ADDR_SEED)
  ) u_addr_gen (
    .clk        (clk),
    .rstn       (rstn),
    .seed_i     (seed_c),
    .load_i     (load_c),
    .advance_i  (adv_c),
    .load_val_i (lfsr_step_addr(in_addr)),
    .value_o    (addr_exp)
  );

  assign mismatch = (in_data != data_exp) || (in_addr != addr_exp);
`else
  logic unused_addr;
  assign unused_addr = ^in_addr;
  assign mismatch    = (in_data != data_exp);
`endif

  // Next-state, counter and LFSR-control logic; stop beats start.
  always_comb begin
    state_d    = state_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    consec_d   = consec_q;
    seed_c     = 1'b0;
    load_c     = 1'b0;
    adv_c      = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d    = ST_CHECK;
      err_cnt_d  = '0;
      word_cnt_d = '0;
      consec_d   = '0;
      seed_c     = 1'b1;
    end else if (accept) begin
      word_cnt_d = word_cnt_q + WORD_W'(1);
      case (state_q)
        ST_CHECK: begin
          adv_c = 1'b1;
          if (mismatch) begin
            err_d    = 1'b1;
            consec_d = CONSEC_W'(consec_inc);
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            if (consec_inc >= CW1'(LOSS_THRESH)) begin
              state_d = ST_LOST;
            end
          end else begin
            consec_d = '0;
          end
        end
        ST_LOST: begin
          load_c   = 1'b1;
          consec_d = '0;
          state_d  = ST_CHECK;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    locked_d = (state_d == ST_CHECK);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
      consec_q   <= '0;
    end else begin
      state_q    <= state_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
      consec_q   <= consec_d;
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign err_count  = err_cnt_q;
  assign word_count = word_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed scenarios plus random traffic
// compared against a polynomial-arithmetic reference model.
module tb_lfsr_checker;

  localparam int unsigned ERR_W   = 4;
  localparam int unsigned THRESH  = 8;
  localparam int          ERR_MAX = (1 << ERR_W) - 1;

  logic             clk;
  logic             rstn;
  logic             start;
  logic             stop;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [9:0]       in_addr;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic [31:0]      word_count;

  int checks;
  int errors;

  lfsr_checker #(
    .ERR_CNT_W   (ERR_W),
    .LOSS_THRESH (THRESH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .stop       (stop),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_addr    (in_addr),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef enum int {M_IDLE, M_CHECK, M_LOST} mstate_t;
  mstate_t     m_st;
  logic [31:0] m_exp;
  logic [9:0]  m_aexp;
  int          m_err;
  int          m_word;
  int          m_consec;
  bit          m_errp;

  // Multiply by x modulo x^32+x^22+x^2+x+1
  function automatic logic [31:0] mulx32(input logic [31:0] d);
    logic [32:0] p;
    p = {d, 1'b0};
    if (p[32]) p = p ^ 33'h1_0040_0007;
    return p[31:0];
  endfunction

  // Multiply by x modulo x^10+x^3+1
  function automatic logic [9:0] mulx10(input logic [9:0] a);
    logic [10:0] p;
    p = {a, 1'b0};
    if (p[10]) p = p ^ 11'h409;
    return p[9:0];
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_exp = 32'hFFFF_FFFF; m_aexp = 10'h3FF;
    m_err = 0; m_word = 0; m_consec = 0; m_errp = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("err",        32'(err),        32'(m_errp));
    chk("err_count",  32'(err_count),  32'(m_err));
    chk("word_count", word_count,      32'(m_word));
    chk("locked",     32'(locked),     32'(m_st == M_CHECK));
  endtask

  // One clock of stimulus; model advances by the rules of the checker.
  task automatic cyc(input bit s, input bit p, input bit v,
                     input logic [31:0] d, input logic [9:0] a);
    bit acc, mm;
    start = s; stop = p; in_valid = v; in_data = d; in_addr = a;
    #1;
    chk("in_ready", 32'(in_ready), 32'((m_st != M_IDLE) && !s && !p));
    acc    = v && (m_st != M_IDLE) && !s && !p;
    m_errp = 1'b0;
    if (p) begin
      m_st = M_IDLE;
    end else if (s) begin
      m_st = M_CHECK; m_exp = 32'hFFFF_FFFF; m_aexp = 10'h3FF;
      m_err = 0; m_word = 0; m_consec = 0;
    end else if (acc && m_st == M_CHECK) begin
      m_word++;
      mm = (d != m_exp);
`ifdef LFSR_CHK_ADDR_EN
      mm = mm || (a != m_aexp);
`endif
      m_exp  = mulx32(m_exp);
      m_aexp = mulx10(m_aexp);
      if (mm) begin
        m_errp = 1'b1;
        if (m_err < ERR_MAX) m_err++;
        m_consec++;
        if (m_consec >= THRESH) m_st = M_LOST;
      end else begin
        m_consec = 0;
      end
    end else if (acc && m_st == M_LOST) begin
      m_word++;
      m_exp = mulx32(d); m_aexp = mulx10(a);
      m_consec = 0; m_st = M_CHECK;
    end
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    chk_outputs();
  endtask

  task automatic beat(input logic [31:0] d, input logic [9:0] a);
    cyc(1'b0, 1'b0, 1'b1, d, a);
  endtask

  task automatic do_start();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 10'h0);
  endtask

  initial begin
    logic [31:0] x;
    checks = 0; errors = 0;
    start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = '0; in_addr = '0;
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'(0));
    chk_outputs();
    rstn = 1'b1;

    // Beats offered in IDLE are ignored
    beat(32'hFFFF_FFFF, 10'h3FF);
    beat(32'h1234_5678, 10'h001);
    chk("idle_word", word_count, 32'd0);

    // Clean two-beat run
    do_start();
    beat(32'hFFFF_FFFF, 10'h3FF);
    beat(32'hFFBF_FFF9, 10'h3F7);
    chk("clean_word", word_count, 32'd2);
    chk("clean_errs", 32'(err_count), 32'd0);
    chk("clean_lock", 32'(locked), 32'd1);

    // Single corrupted beat, then stale data mismatches the advanced stream
    do_start();
    beat(32'hFFFF_FFFF, 10'h3FF);
    beat(32'h0000_0000, 10'h3F7);
    chk("one_err_pulse", 32'(err), 32'd1);
    chk("one_err_cnt", 32'(err_count), 32'd1);
    chk("one_err_lock", 32'(locked), 32'd1);
    beat(32'hFFBF_FFF9, m_aexp);
    chk("stale_err_cnt", 32'(err_count), 32'd2);

    // Loss of lock after THRESH zero beats, resync on the next beat
    do_start();
    for (int i = 0; i < int'(THRESH); i++) beat(32'h0, m_aexp);
    chk("loss_lock", 32'(locked), 32'd0);
    x = $urandom;
    beat(x, 10'(x));
    chk("resync_err", 32'(err), 32'd0);
    chk("resync_lock", 32'(locked), 32'd1);
    beat(mulx32(x), mulx10(10'(x)));
    chk("resync_match", 32'(err), 32'd0);
    chk("resync_cnt", 32'(err_count), 32'd8);

`ifdef LFSR_CHK_ADDR_EN
    // Address mismatch alone flags an error
    do_start();
    beat(32'hFFFF_FFFF, 10'h3FF);
    chk("addr_ok", 32'(err), 32'd0);
    beat(32'hFFBF_FFF9, 10'h3F6);
    chk("addr_bad", 32'(err), 32'd1);
`endif

    // Asynchronous reset in the middle of a beat
    do_start();
    beat(32'hFFFF_FFFF, 10'h3FF);
    beat(32'h0, 10'h0);
    start = 1'b0; in_valid = 1'b1; in_data = 32'hFFBF_FFF9; in_addr = 10'h3F7;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk_outputs();
    @(posedge clk);
    #1;
    chk_outputs();
    in_valid = 1'b0;
    rstn = 1'b1;
    beat(32'hFFFF_FFFF, 10'h3FF);
    chk("post_rst_idle", word_count, 32'd0);
    do_start();
    beat(32'hFFFF_FFFF, 10'h3FF);
    chk("post_rst_errs", 32'(err_count), 32'd0);
    chk("post_rst_word", word_count, 32'd1);

    // Simultaneous start and stop: stop wins
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 10'h3FF);
    chk("ss_lock", 32'(locked), 32'd0);
    #1;
    chk("ss_ready", 32'(in_ready), 32'd0);
    beat(32'hFFFF_FFFF, 10'h3FF);
    chk("ss_word", word_count, 32'd1);

    // Error counter saturates
    do_start();
    for (int i = 0; i < 20; i++) begin
      beat(~m_exp, m_aexp);
      beat(m_exp, m_aexp);
    end
    chk("sat_cnt", 32'(err_count), 32'(ERR_MAX));

    // Random traffic
    do_start();
    for (int i = 0; i < 600; i++) begin
      bit s, p, v;
      logic [31:0] d;
      logic [9:0]  a;
      s = ($urandom_range(0, 59) == 0);
      p = ($urandom_range(0, 89) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (m_st == M_LOST || $urandom_range(0, 4) == 0) d = $urandom;
      else if ($urandom_range(0, 9) == 0) d = 32'h0;
      else d = m_exp;
      a = ($urandom_range(0, 15) == 0) ? 10'($urandom) : m_aexp;
      cyc(s, p, v, d, a);
      if (m_st == M_IDLE && $urandom_range(0, 3) == 0) do_start();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
